// File: rtl/tl_a_burst_arbiter.sv
// Round-robin TileLink A-channel arbiter that holds the grant across
// multi-beat bursts and while a request is stalled by the downstream.
module tl_a_burst_arbiter #(
    parameter int unsigned NumHosts  = 3,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned MaxSize   = 6,
    parameter int unsigned SizeWidth = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumHosts-1:0]                 req_valid_i,
    output logic [NumHosts-1:0]                 req_ready_o,
    input  logic [NumHosts-1:0][2:0]            req_opcode_i,
    input  logic [NumHosts-1:0][SizeWidth-1:0]  req_size_i,
    output logic                                dev_valid_o,
    input  logic                                dev_ready_i,
    output logic [NumHosts-1:0]                 grant_o,
    output logic [$clog2(NumHosts)-1:0]         grant_idx_o,
    output logic                                locked_o
);

    localparam int unsigned IdxWidth = $clog2(NumHosts);
    localparam int unsigned BeatLog  = $clog2(DataWidth / 8);
    localparam int unsigned BurstLog = (MaxSize > BeatLog) ? (MaxSize - BeatLog) : 0;
    localparam int unsigned CntWidth = BurstLog + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IdxWidth-1:0]   prio_q, prio_d;
    logic [IdxWidth-1:0]   owner_q, owner_d;
    logic [CntWidth-1:0]   beats_q, beats_d;

    logic                  win_found;
    logic [IdxWidth-1:0]   win_idx;
    logic [IdxWidth-1:0]   sel_idx;
    logic [CntWidth-1:0]   sel_beats;
    logic                  fire;

    // Number of beats carried by a message; only data-bearing opcodes span beats.
    function automatic logic [CntWidth-1:0] beats_of(input logic [2:0]           op,
                                                     input logic [SizeWidth-1:0] sz);
        int unsigned eff;
        eff = 32'(sz);
        if (eff > MaxSize) begin
            eff = MaxSize;
        end
        if ((op <= 3'd3) && (eff > BeatLog)) begin
            return CntWidth'(1) << (eff - BeatLog);
        end
        return CntWidth'(1);
    endfunction

    // Round-robin successor of a host index.
    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        if (idx == IdxWidth'(NumHosts - 1)) begin
            return '0;
        end
        return IdxWidth'(idx + 1'b1);
    endfunction

    // First valid host scanning upward from the priority pointer, wrapping.
    always_comb begin
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NumHosts; k++) begin
            cand = 32'(prio_q) + k;
            if (cand >= NumHosts) begin
                cand = cand - NumHosts;
            end
            if (!win_found && req_valid_i[IdxWidth'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IdxWidth'(cand);
            end
        end
    end

    // Grant is live arbitration in IDLE and frozen on the owner otherwise.
    always_comb begin
        grant_o = '0;
        sel_idx = (state_q == IDLE) ? win_idx : owner_q;
        if ((state_q != IDLE) || win_found) begin
            grant_o[sel_idx] = 1'b1;
        end
    end

    // Handshake plumbing and status outputs.
    always_comb begin
        grant_idx_o = sel_idx;
        dev_valid_o = |(req_valid_i & grant_o);
        req_ready_o = grant_o & {NumHosts{dev_ready_i}};
        locked_o    = (state_q != IDLE);
        fire        = dev_valid_o & dev_ready_i;
        sel_beats   = beats_of(req_opcode_i[sel_idx], req_size_i[sel_idx]);
    end

    // Next-state logic for the lock FSM, pointer, owner and beat counter.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    if (fire) begin
                        if (sel_beats == CntWidth'(1)) begin
                            prio_d = next_idx(win_idx);
                        end else begin
                            state_d = BURST;
                            beats_d = sel_beats - CntWidth'(1);
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (fire) begin
                    if (sel_beats == CntWidth'(1)) begin
                        state_d = IDLE;
                        prio_d  = next_idx(owner_q);
                    end else begin
                        state_d = BURST;
                        beats_d = sel_beats - CntWidth'(1);
                    end
                end
            end
            BURST: begin
                if (fire) begin
                    beats_d = beats_q - CntWidth'(1);
                    if (beats_q == CntWidth'(1)) begin
                        state_d = IDLE;
                        prio_d  = next_idx(owner_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any lock immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
        end
    end

endmodule
